// File: rtl/apb3_slot_bridge_wd_pkg.sv
// apb3_slot_bridge_wd_pkg: shared FSM state type, watchdog counter width and slot-index width helper
package apb3_slot_bridge_wd_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam int CNT_W = 16;
  function automatic int slot_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb3_slot_bridge_wd_if.sv
// apb3_slot_bridge_wd_if: master-side and slot-side APB3 signals; slave modport is the bridge view, master modport is the upstream master plus peripherals
interface apb3_slot_bridge_wd_if #(
  parameter int APB_DWIDTH = 32,
  parameter int NSLOTS = 16
);
  logic psel, penable, pwrite;
  logic [31:0] paddr;
  logic [APB_DWIDTH-1:0] pwdata, prdata;
  logic pready, pslverr;
  logic [NSLOTS-1:0] psels;
  logic penables, pwrites;
  logic [31:0] paddrs;
  logic [APB_DWIDTH-1:0] pwdatas;
  logic [NSLOTS*APB_DWIDTH-1:0] prdatas;
  logic [NSLOTS-1:0] preadys, pslverrs;
  modport master (output psel, penable, pwrite, paddr, pwdata, prdatas, preadys, pslverrs,
                  input prdata, pready, pslverr, psels, penables, pwrites, paddrs, pwdatas);
  modport slave (input psel, penable, pwrite, paddr, pwdata, prdatas, preadys, pslverrs,
                 output prdata, pready, pslverr, psels, penables, pwrites, paddrs, pwdatas);
endinterface

// File: rtl/apb3_slot_bridge_wd_counter.sv
// apb3_slot_bridge_wd_counter: 16-bit saturating wait counter; ports clk, rst_n, clr, en, limit, expired (limit 0 never expires)
module apb3_slot_bridge_wd_counter import apb3_slot_bridge_wd_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (en && ~&cnt) ? cnt + 1'b1 : cnt;
  assign expired = |limit && cnt >= limit;
endmodule

// File: rtl/apb3_slot_bridge_wd.sv
// apb3_slot_bridge_wd: APB3 slot decoder/bridge with per-transfer watchdog; ports clk, rst_n, bus (slave modport), timeout_evt pulse, timeout_slot
module apb3_slot_bridge_wd import apb3_slot_bridge_wd_pkg::*; #(
  parameter int          APB_DWIDTH     = 32,
  parameter int          MADDR_BITS     = 16,
  parameter int          NSLOTS         = 16,
  parameter logic [15:0] SLOT_ENABLE    = 16'h007E,
  parameter int          TIMEOUT_CYCLES = 255,
  localparam int         SLOT_W         = slot_w(NSLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb3_slot_bridge_wd_if.slave  bus,
  output logic                  timeout_evt,
  output logic [SLOT_W-1:0]     timeout_slot
);
  state_t state;
  logic [SLOT_W-1:0] idx;
  logic [SLOT_W-1:0] sel;
  logic expired;
  assign sel = bus.paddr[MADDR_BITS-1 -: SLOT_W];
  apb3_slot_bridge_wd_counter u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != ACCESS),
    .en      (state == ACCESS && !bus.preadys[idx]),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bus.psels    <= '0;
      bus.penables <= 1'b0;
      bus.pwrites  <= 1'b0;
      bus.paddrs   <= '0;
      bus.pwdatas  <= '0;
      bus.prdata   <= '0;
      bus.pready   <= 1'b0;
      bus.pslverr  <= 1'b0;
      timeout_evt  <= 1'b0;
      timeout_slot <= '0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE:
          if (bus.psel && !bus.penable) begin
            bus.paddrs  <= bus.paddr;
            bus.pwrites <= bus.pwrite;
            bus.pwdatas <= bus.pwdata;
            idx         <= sel;
            if (SLOT_ENABLE[sel]) begin
              bus.psels <= NSLOTS'(1) << sel;
              state     <= SETUP;
            end else begin
              bus.prdata  <= '0;
              bus.pslverr <= 1'b1;
              bus.pready  <= 1'b1;
              state       <= DONE;
            end
          end
        SETUP: begin
          bus.penables <= 1'b1;
          state        <= ACCESS;
        end
        ACCESS:
          // ready is tested first so it wins over a same-cycle watchdog expiry
          if (bus.preadys[idx] || expired) begin
            bus.prdata   <= (bus.preadys[idx] && !bus.pwrites) ? bus.prdatas[idx*APB_DWIDTH +: APB_DWIDTH] : '0;
            bus.pslverr  <= bus.preadys[idx] ? bus.pslverrs[idx] : 1'b1;
            timeout_evt  <= !bus.preadys[idx];
            timeout_slot <= bus.preadys[idx] ? timeout_slot : idx;
            bus.psels    <= '0;
            bus.penables <= 1'b0;
            bus.pready   <= 1'b1;
            state        <= DONE;
          end
        DONE: begin
          bus.prdata  <= '0;
          bus.pslverr <= 1'b0;
          bus.pready  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb3_slot_bridge_wd.sv
// tb_apb3_slot_bridge_wd: randomized scoreboard bench for apb3_slot_bridge_wd
module tb_apb3_slot_bridge_wd;
  localparam int TO = 8;
  localparam logic [15:0] EN = 16'h007E;
  typedef struct {
    logic [3:0]  slot;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          tmo;
    int          nsel;
    int          nen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_evt;
  logic [3:0] timeout_slot;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [3:0] tgt = '0;
  int wt = 0;
  int ws_cnt = 0;
  logic [15:0] nrdy = '0;
  int acc = 0, nsel = 0, nen = 0, nevt = 0, nbad = 0;
  logic [3:0] last_ts = '0;

  apb3_slot_bridge_wd_if #(.APB_DWIDTH(32), .NSLOTS(16)) bus ();

  apb3_slot_bridge_wd #(
    .APB_DWIDTH(32), .MADDR_BITS(16), .NSLOTS(16), .SLOT_ENABLE(EN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_evt(timeout_evt), .timeout_slot(timeout_slot)
  );

  always #5 clk = ~clk;

  // peripheral model: the target slot becomes ready after wt wait states (never when wt < 0)
  always_comb begin
    bus.preadys = nrdy;
    bus.preadys[tgt] = bus.penables && bus.psels[tgt] && wt >= 0 && ws_cnt >= wt;
  end
  always @(posedge clk) ws_cnt <= (bus.penables && !bus.preadys[tgt]) ? ws_cnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input bit e, input int w);
    exp_t r;
    r.slot = addr[15:12]; r.wr = wr; r.addr = addr; r.wdata = wd;
    if (!EN[r.slot]) begin
      r.lat = 1; r.rdata = '0; r.err = 1'b1; r.tmo = 0; r.nsel = 0; r.nen = 0;
    end else if (w >= 0 && w <= TO) begin
      r.lat = 3 + w; r.rdata = wr ? '0 : rd; r.err = e; r.tmo = 0; r.nsel = 2 + w; r.nen = 1 + w;
    end else begin
      r.lat = TO + 3; r.rdata = '0; r.err = 1'b1; r.tmo = 1; r.nsel = TO + 2; r.nen = TO + 1;
    end
    return r;
  endfunction

  task automatic setup_slots(input logic [31:0] addr, input logic [31:0] rd, input bit e, input int w);
    tgt = addr[15:12];
    wt = w;
    for (int i = 0; i < 16; i++) bus.prdatas[i*32 +: 32] = $urandom;
    bus.prdatas[tgt*32 +: 32] = rd;
    bus.pslverrs = 16'($urandom);
    bus.pslverrs[tgt] = e;
    nrdy = 16'($urandom);
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input bit e, input int w, input bit b2b);
    int k;
    setup_slots(addr, rd, e, w);
    q.push_back(model(wr, addr, wd, rd, e, w));
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(posedge clk); #1 bus.penable = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.pready && k < 200);
    if (!bus.pready) begin
      checks++; errors++;
      $display("FAIL pready_wait: got no pready after %0d cycles, expected completion", k);
      if (q.size() > 0) void'(q.pop_front());
    end
    @(posedge clk); #1;
    if (!b2b) begin
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic abort_test;
    setup_slots(32'h0000_3000, 32'h0, 1'b0, -1);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h0000_3000;
    @(posedge clk); #1 bus.penable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_psels", 32'(bus.psels), 0);
    chk("abort_penables", 32'(bus.penables), 0);
    chk("abort_pready", 32'(bus.pready), 0);
    chk("abort_paddrs", bus.paddrs, 0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready_after_edge", 32'(bus.pready), 0);
    rst_n = 1'b1;
    last_ts = '0;
    @(posedge clk); #1;
  endtask

  // monitor: accumulates per-transfer observations during the master access phase
  always @(negedge clk) begin
    if (!(bus.psel && bus.penable)) begin
      acc = 0; nsel = 0; nen = 0; nevt = 0; nbad = 0;
    end else begin
      acc++;
      if (q.size() > 0) begin
        if (bus.psels == (16'd1 << q[0].slot)) nsel++;
        else if (bus.psels != 0) nbad++;
        if (bus.penables && (bus.paddrs !== q[0].addr || bus.pwrites !== q[0].wr || bus.pwdatas !== q[0].wdata)) nbad++;
      end
      if (bus.penables) nen++;
      if (timeout_evt) nevt++;
      if (!bus.pready && (bus.prdata != 0 || bus.pslverr)) nbad++;
      if (bus.pready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pready: got pready with empty scoreboard, expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 32'(acc), 32'(e.lat));
          chk("prdata", bus.prdata, e.rdata);
          chk("pslverr", 32'(bus.pslverr), 32'(e.err));
          chk("timeout_evt_cycles", 32'(nevt), 32'(e.tmo));
          if (e.tmo != 0) last_ts = e.slot;
          chk("timeout_slot", 32'(timeout_slot), 32'(last_ts));
          chk("psels_cycles", 32'(nsel), 32'(e.nsel));
          chk("penables_cycles", 32'(nen), 32'(e.nen));
          chk("protocol_glitches", 32'(nbad), 0);
        end
        acc = 0; nsel = 0; nen = 0; nevt = 0; nbad = 0;
      end
    end
  end

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    bus.prdatas = '0; bus.pslverrs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_psels", 32'(bus.psels), 0);
    chk("reset_penables", 32'(bus.penables), 0);
    chk("reset_pready", 32'(bus.pready), 0);
    chk("reset_pslverr", 32'(bus.pslverr), 0);
    chk("reset_prdata", bus.prdata, 0);
    chk("reset_timeout", 32'({timeout_evt, timeout_slot}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 32'h0000_1004, 32'hA5A5_0001, 32'hDEAD_0001, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h0000_3000, 32'h0, 32'h1234_5678, 1'b0, 4, 1'b0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h0000_5008, 32'h0, 32'h5555_5555, 1'b0, -1, 1'b0);
    xfer(1'b0, 32'h0000_2000, 32'h0, 32'h2222_0002, 1'b0, 1, 1'b0);
    xfer(1'b0, 32'h0000_4000, 32'h0, 32'h4444_0004, 1'b1, 1, 1'b0);
    xfer(1'b0, 32'h0000_4004, 32'h0, 32'h4444_0008, 1'b0, TO, 1'b0);
    xfer(1'b0, 32'h0000_4008, 32'h0, 32'h4444_000C, 1'b0, TO + 1, 1'b0);
    xfer(1'b1, 32'h0000_1010, 32'hB0B0_0001, 32'h0, 1'b0, 0, 1'b1);
    xfer(1'b0, 32'h0000_6020, 32'h0, 32'h6666_0006, 1'b0, 2, 1'b0);
    abort_test();
    xfer(1'b0, 32'h0000_3004, 32'h0, 32'h3333_0003, 1'b0, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int r, w;
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      w = r <= 5 ? r : r == 6 ? TO : r == 7 ? TO + 1 : r == 8 ? -1 : TO - 1;
      xfer(1'($urandom), a, $urandom, $urandom, 1'($urandom), w, 1'($urandom));
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
